alu_share_ctrl: RTL and testbench

//  Sequences one shared combinational ALU (ctrl: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR, 9 SRA, 10 LUI, 11 BNE) among N_REQ requesters.

---
 rtl/alu_share_ctrl_pkg.sv | 29 ++
 rtl/alu_share_ctrl_if.sv | 40 ++++
 rtl/alu_share_ctrl_arbiter.sv | 33 +++
 rtl/alu_share_ctrl.sv | 114 +++++++++++
 tb/tb_alu_share_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// ALU control codes, FSM state encoding and ctrl legality check shared by alu_share_ctrl.
package alu_ctrl_pkg;

    localparam int unsigned ALU_AND = 0;
    localparam int unsigned ALU_OR  = 1;
    localparam int unsigned ALU_ADD = 2;
    localparam int unsigned ALU_SUB = 6;
    localparam int unsigned ALU_SLT = 7;
    localparam int unsigned ALU_SRA = 9;
    localparam int unsigned ALU_LUI = 10;
    localparam int unsigned ALU_BNE = 11;
    localparam int unsigned ALU_NOR = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    function automatic logic is_legal_ctrl(input int unsigned ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
            ALU_SRA, ALU_LUI, ALU_BNE, ALU_NOR: is_legal_ctrl = 1'b1;
            default:                            is_legal_ctrl = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request, ALU and response bus of alu_share_ctrl; slave is the controller, master the issue side / ALU / consumer.
interface alu_share_ctrl_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]             req_valid_i;
    logic [N_REQ-1:0]             req_ready_o;
    logic [N_REQ-1:0][DATA_W-1:0] req_src1_i;
    logic [N_REQ-1:0][DATA_W-1:0] req_src2_i;
    logic [N_REQ-1:0][CTRL_W-1:0] req_ctrl_i;
    logic [DATA_W-1:0]            alu_src1_o;
    logic [DATA_W-1:0]            alu_src2_o;
    logic [CTRL_W-1:0]            alu_ctrl_o;
    logic [DATA_W-1:0]            alu_result_i;
    logic                         alu_zero_i;
    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [IDX_W-1:0]             rsp_id_o;
    logic [DATA_W-1:0]            rsp_result_o;
    logic                         rsp_zero_o;
    logic                         rsp_err_o;

    modport slave (
        input  req_valid_i, req_src1_i, req_src2_i, req_ctrl_i,
        input  alu_result_i, alu_zero_i, rsp_ready_i,
        output req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
        output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_src1_i, req_src2_i, req_ctrl_i,
        output alu_result_i, alu_zero_i, rsp_ready_i,
        input  req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
        input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o
    );

endinterface

// File: rtl/alu_share_ctrl_arbiter.sv
// Combinational rotating-priority arbiter: first valid requester at or after ptr_i, wrapping.
module alu_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    always_comb begin
        int         lane;
        logic       found;
        logic [IDX_W-1:0] lane_idx;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        lane        = 0;
        lane_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            lane = int'(ptr_i) + i;
            if (lane >= N_REQ) lane = lane - N_REQ;
            lane_idx = IDX_W'(lane);
            if (!found && valid_i[lane_idx]) begin
                found             = 1'b1;
                grant_o[lane_idx] = 1'b1;
                grant_idx_o       = lane_idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequences one external combinational ALU among N_REQ requesters and returns id-tagged responses.
// Define ALU_SHARE_FIXED_PRIO_EN for lowest-index-first priority instead of round-robin.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_share_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef struct packed {
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [CTRL_W-1:0] ctrl;
    } alu_op_t;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  id_q, id_d;
    alu_op_t           op_q, op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;
    logic [N_REQ-1:0]  grant_oh;
    logic [IDX_W-1:0]  grant_idx;

    alu_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .valid_i     (bus.req_valid_i),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx)
    );

    // Ready is masked by the async reset so every output reads 0 while it is held.
    assign bus.req_ready_o  = (state_q == IDLE && !rst_i) ? grant_oh : '0;
    assign bus.alu_src1_o   = op_q.src1;
    assign bus.alu_src2_o   = op_q.src2;
    assign bus.alu_ctrl_o   = op_q.ctrl;
    assign bus.rsp_valid_o  = (state_q == RESP);
    assign bus.rsp_id_o     = id_q;
    assign bus.rsp_result_o = res_q;
    assign bus.rsp_zero_o   = zero_q;
    assign bus.rsp_err_o    = err_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        op_d     = op_q;
        res_d    = res_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (|grant_oh) begin
                    id_d = grant_idx;
`ifdef ALU_SHARE_FIXED_PRIO_EN
                    rr_ptr_d = '0;
`else
                    rr_ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
`endif
                    // Illegal ops never touch the ALU registers and skip straight to the response.
                    if (is_legal_ctrl(32'(bus.req_ctrl_i[grant_idx]))) begin
                        op_d.src1 = bus.req_src1_i[grant_idx];
                        op_d.src2 = bus.req_src2_i[grant_idx];
                        op_d.ctrl = bus.req_ctrl_i[grant_idx];
                        state_d   = ISSUE;
                    end else begin
                        res_d   = '0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                res_d   = bus.alu_result_i;
                zero_d  = bus.alu_zero_i;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP:    if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed ops queue expected responses, a monitor checks each handshake.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_acc = 0;
    bit   seen_first = 1'b0;
    exp_t exp_q[$];
    int   acc_q[$];

    alu_share_ctrl_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    alu_share_ctrl #(.N_REQ(N_REQ), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the shared ALU sitting next to the controller.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (32'(c))
            ALU_AND: alu_f = a & b;
            ALU_OR:  alu_f = a | b;
            ALU_ADD: alu_f = a + b;
            ALU_SUB: alu_f = a - b;
            ALU_SLT: alu_f = {31'd0, $signed(a) < $signed(b)};
            ALU_NOR: alu_f = ~(a | b);
            ALU_SRA: alu_f = $signed(b) >>> a[4:0];
            ALU_LUI: alu_f = {b[15:0], 16'd0};
            ALU_BNE: alu_f = {31'd0, a != b};
            default: alu_f = 32'd0;
        endcase
    endfunction

    always_comb begin
        logic [31:0] r;
        r                = alu_f(bus.alu_src1_o, bus.alu_src2_o, bus.alu_ctrl_o);
        bus.alu_result_i = r;
        bus.alu_zero_i   = (r == 32'd0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
        end
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic push_exp(input int id, input logic [31:0] res, input logic z, input logic e, input int lat);
        exp_q.push_back('{id, res, z, e, lat});
    endtask

    task automatic wait_grant(input logic k);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.req_ready_o[k] && t < 40);
        if (!bus.req_ready_o[k]) tmo("accept");
        @(posedge clk);
        #1;
        bus.req_valid_i[k] = 1'b0;
    endtask

    task automatic issue(input logic k, input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] c);
        bus.req_src1_i[k]  = s1;
        bus.req_src2_i[k]  = s2;
        bus.req_ctrl_i[k]  = c;
        bus.req_valid_i[k] = 1'b1;
        wait_grant(k);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 80) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) tmo("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"},  32'(bus.req_ready_o),  32'd0);
        chk({tag, "_alu_src1"},   bus.alu_src1_o,        32'd0);
        chk({tag, "_alu_src2"},   bus.alu_src2_o,        32'd0);
        chk({tag, "_alu_ctrl"},   32'(bus.alu_ctrl_o),   32'd0);
        chk({tag, "_rsp_valid"},  32'(bus.rsp_valid_o),  32'd0);
        chk({tag, "_rsp_id"},     32'(bus.rsp_id_o),     32'd0);
        chk({tag, "_rsp_result"}, bus.rsp_result_o,      32'd0);
        chk({tag, "_rsp_zero"},   32'(bus.rsp_zero_o),   32'd0);
        chk({tag, "_rsp_err"},    32'(bus.rsp_err_o),    32'd0);
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_src1_i  = '0;
        bus.req_src2_i  = '0;
        bus.req_ctrl_i  = '0;
        bus.rsp_ready_i = 1'b1;
        fork
            begin : stim
                int t;
                repeat (2) @(posedge clk);
                #1;
                chk_zero("reset");
                rst = 1'b0;
                @(posedge clk);
                #1;

                // ADD 5+7 from requester 0
                push_exp(0, 32'd12, 1'b0, 1'b0, 3);
                issue(1'b0, 32'd5, 32'd7, 4'(ALU_ADD));
                drain();

                // illegal ctrl from requester 1: ALU registers keep the previous op
                push_exp(1, 32'd0, 1'b1, 1'b1, 1);
                issue(1'b1, 32'hDEAD, 32'hBEEF, 4'd5);
                chk("illegal_alu_src1", bus.alu_src1_o, 32'd5);
                chk("illegal_alu_src2", bus.alu_src2_o, 32'd7);
                chk("illegal_alu_ctrl", 32'(bus.alu_ctrl_o), 32'd2);
                drain();

                // both requesters continuously valid, SUB 9-9
                for (int i = 0; i < 4; i++) push_exp(FIXED ? 0 : i % 2, 32'd0, 1'b1, 1'b0, 3);
                for (int k = 0; k < 2; k++) begin
                    bus.req_src1_i[k] = 32'd9;
                    bus.req_src2_i[k] = 32'd9;
                    bus.req_ctrl_i[k] = 4'(ALU_SUB);
                end
                t = n_acc;
                bus.req_valid_i = 2'b11;
                for (int w = 0; w < 80 && n_acc < t + 4; w++) begin
                    @(negedge clk);
                    #1;
                end
                if (n_acc < t + 4) tmo("contend");
                @(posedge clk);
                #1;
                bus.req_valid_i = 2'b00;
                drain();

                // backpressure: AND result 0 held while requester 1 waits
                bus.rsp_ready_i = 1'b0;
                push_exp(0, 32'd0, 1'b1, 1'b0, 3);
                issue(1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'(ALU_AND));
                push_exp(1, 32'd7, 1'b0, 1'b0, 3);
                bus.req_src1_i[1]  = 32'd3;
                bus.req_src2_i[1]  = 32'd4;
                bus.req_ctrl_i[1]  = 4'(ALU_OR);
                bus.req_valid_i[1] = 1'b1;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!bus.rsp_valid_o && t < 10);
                if (!bus.rsp_valid_o) tmo("bp_valid");
                for (int i = 0; i < 6; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
                    chk("bp_rsp_result", bus.rsp_result_o, 32'd0);
                    chk("bp_rsp_zero", 32'(bus.rsp_zero_o), 32'd1);
                    chk("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
                end
                @(posedge clk);
                #1;
                bus.rsp_ready_i = 1'b1;
                wait_grant(1'b1);
                drain();

                // async reset during CAPTURE discards the op and restarts arbitration at requester 0
                issue(1'b0, 32'd1, 32'd2, 4'(ALU_ADD));
                @(posedge clk);
                #2;
                rst = 1'b1;
                exp_q.delete();
                acc_q.delete();
                #1;
                chk_zero("rst_mid");
                @(posedge clk);
                #1;
                rst = 1'b0;
                push_exp(0, 32'd30, 1'b0, 1'b0, 3);
                push_exp(1, 32'hFFFF_FFFE, 1'b0, 1'b0, 3);
                bus.req_src1_i[0] = 32'd10;
                bus.req_src2_i[0] = 32'd20;
                bus.req_ctrl_i[0] = 4'(ALU_ADD);
                bus.req_src1_i[1] = 32'd3;
                bus.req_src2_i[1] = 32'd5;
                bus.req_ctrl_i[1] = 4'(ALU_SUB);
                bus.req_valid_i   = 2'b11;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (bus.req_ready_o == 2'b00 && t < 20);
                chk("rst_first_grant", 32'(bus.req_ready_o), 32'd1);
                @(posedge clk);
                #1;
                bus.req_valid_i[0] = 1'b0;
                wait_grant(1'b1);
                drain();

                // SRA, LUI, SLT, NOR
                push_exp(0, 32'hF800_0000, 1'b0, 1'b0, 3);
                issue(1'b0, 32'd4, 32'h8000_0000, 4'(ALU_SRA));
                push_exp(1, 32'h1234_0000, 1'b0, 1'b0, 3);
                issue(1'b1, 32'd0, 32'h0000_1234, 4'(ALU_LUI));
                push_exp(0, 32'd1, 1'b0, 1'b0, 3);
                issue(1'b0, 32'hFFFF_FFFF, 32'd1, 4'(ALU_SLT));
                push_exp(1, 32'hFFFF_FFFF, 1'b0, 1'b0, 3);
                issue(1'b1, 32'd0, 32'd0, 4'(ALU_NOR));
                drain();
            end
            begin : watch
                forever begin
                    @(negedge clk);
                    if (|(bus.req_valid_i & bus.req_ready_o)) begin
                        acc_q.push_back(cyc);
                        n_acc++;
                    end
                end
            end
            begin : mon
                exp_t x;
                forever begin
                    @(negedge clk);
                    if (!bus.rsp_valid_o) begin
                        seen_first = 1'b0;
                    end else begin
                        if (!seen_first) begin
                            seen_first = 1'b1;
                            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                                n_chk++;
                                n_err++;
                                $display("FAIL rsp_unexpected: got id %0d, want no response", bus.rsp_id_o);
                            end else begin
                                chk("latency", 32'(cyc - acc_q[0]), 32'(exp_q[0].lat));
                            end
                        end
                        if (bus.rsp_ready_i && exp_q.size() != 0) begin
                            x = exp_q.pop_front();
                            if (acc_q.size() != 0) void'(acc_q.pop_front());
                            chk("rsp_id", 32'(bus.rsp_id_o), 32'(x.id));
                            chk("rsp_result", bus.rsp_result_o, x.res);
                            chk("rsp_zero", 32'(bus.rsp_zero_o), 32'(x.zero));
                            chk("rsp_err", 32'(bus.rsp_err_o), 32'(x.err));
                        end
                    end
                end
            end
        join_any
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
